// File: rtl/score_player_if.sv
// Score player bus: control pulses, score write port and note/display outputs.
// The player module connects through the slave modport; the driver of the
// controls and consumer of the note codes uses the master modport.
interface score_player_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic              pause;
    logic              stop;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [3:0]        high;
    logic [3:0]        med;
    logic [3:0]        low;
    logic [2:0]        cs;
    logic              playing;
    logic              done;

    modport master (
        output start, pause, stop, wr_en, wr_addr, wr_data,
        input  high, med, low, cs, playing, done
    );

    modport slave (
        input  start, pause, stop, wr_en, wr_addr, wr_data,
        output high, med, low, cs, playing, done
    );
endinterface

// File: rtl/score_player.sv
// Score sequencer: steps through a writable memory of note entries on a
// divided beat tick and drives the {high, med, low} note codes plus the cs
// display index. Entry format: [15:12] duration in ticks (0 = end marker),
// [11:8] high, [7:4] med, [3:0] low.
// Optional feature: define SCORE_GAP_EN to insert a one-tick silent gap
// between consecutive notes (the GAP state only exists in that build).
module score_player #(
    parameter int TICK_DIV = 12500000,
    parameter int ADDR_W   = 5,
    parameter bit LOOP     = 1'b0
) (
    input  logic            sys_clk,
    input  logic            rst,
    score_player_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef SCORE_GAP_EN
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;
`endif

    logic [15:0]       mem [DEPTH];

    state_t            state_q, state_d;
    state_t            resume_q, resume_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        remain_q, remain_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       note_q, note_d;
    logic [2:0]        cs_q, cs_d;
    logic              done_q, done_d;

    logic [ADDR_W-1:0] next_addr;
    logic [15:0]       entry_next;
    logic [15:0]       entry_zero;
    logic [11:0]       note_cur;
    logic              next_ok;
    logic              wrap_ok;
    logic              tick;
    logic              counting;

    // Score memory write port; contents deliberately survive reset.
    always_ff @(posedge sys_clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Combinational lookahead reads so a load sees writes up to the cycle before.
    assign next_addr  = addr_q + ADDR_W'(1);
    assign entry_next = mem[next_addr];
    assign entry_zero = mem[0];
    assign note_cur   = mem[addr_q][11:0];
    assign next_ok    = (entry_next[15:12] != 4'd0);
    assign wrap_ok    = LOOP && (entry_zero[15:12] != 4'd0);
    assign tick       = (cnt_q == CNT_W'(TICK_DIV - 1));
`ifdef SCORE_GAP_EN
    assign counting   = (state_q == S_PLAY) || (state_q == S_GAP);
`else
    assign counting   = (state_q == S_PLAY);
`endif

    // State and output registers; asynchronous reset silences immediately.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            resume_q <= S_PLAY;
            addr_q   <= '0;
            remain_q <= '0;
            cnt_q    <= '0;
            note_q   <= '0;
            cs_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            cnt_q    <= cnt_d;
            note_q   <= note_d;
            cs_q     <= cs_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: stop beats start beats pause; a tick that coincides
    // with pause is dropped (the counter still advances, remain does not).
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        cnt_d    = cnt_q;
        note_d   = note_q;
        cs_d     = cs_q;
        done_d   = 1'b0;

        if (counting) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        if (bus.stop) begin
            state_d  = S_IDLE;
            addr_d   = '0;
            remain_d = '0;
            cnt_d    = '0;
            note_d   = '0;
            cs_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        cnt_d  = '0;
                        addr_d = '0;
                        cs_d   = '0;
                        if (entry_zero[15:12] != 4'd0) begin
                            note_d   = entry_zero[11:0];
                            remain_d = entry_zero[15:12];
                            state_d  = S_PLAY;
                        end else begin
                            // Empty score: finish straight away.
                            note_d   = '0;
                            remain_d = '0;
                            done_d   = 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (bus.pause) begin
                        resume_d = S_PLAY;
                        state_d  = S_PAUSE;
                        note_d   = '0;
                    end else if (tick) begin
                        if (remain_q > 4'd1) begin
                            remain_d = remain_q - 4'd1;
                        end else if (next_ok) begin
`ifdef SCORE_GAP_EN
                            // Silent articulation tick; cs keeps the old index.
                            state_d = S_GAP;
                            note_d  = '0;
`else
                            addr_d   = next_addr;
                            note_d   = entry_next[11:0];
                            remain_d = entry_next[15:12];
                            cs_d     = 3'(next_addr);
`endif
                        end else if (wrap_ok) begin
                            addr_d   = '0;
                            note_d   = entry_zero[11:0];
                            remain_d = entry_zero[15:12];
                            cs_d     = '0;
                        end else begin
                            state_d  = S_IDLE;
                            addr_d   = '0;
                            remain_d = '0;
                            note_d   = '0;
                            cs_d     = '0;
                            done_d   = 1'b1;
                        end
                    end
                end
`ifdef SCORE_GAP_EN
                S_GAP: begin
                    if (bus.pause) begin
                        resume_d = S_GAP;
                        state_d  = S_PAUSE;
                        note_d   = '0;
                    end else if (tick) begin
                        if (next_ok) begin
                            state_d  = S_PLAY;
                            addr_d   = next_addr;
                            note_d   = entry_next[11:0];
                            remain_d = entry_next[15:12];
                            cs_d     = 3'(next_addr);
                        end else if (wrap_ok) begin
                            state_d  = S_PLAY;
                            addr_d   = '0;
                            note_d   = entry_zero[11:0];
                            remain_d = entry_zero[15:12];
                            cs_d     = '0;
                        end else begin
                            state_d  = S_IDLE;
                            addr_d   = '0;
                            remain_d = '0;
                            note_d   = '0;
                            cs_d     = '0;
                            done_d   = 1'b1;
                        end
                    end
                end
`endif
                S_PAUSE: begin
                    if (bus.pause) begin
                        // Resume: re-read the note so a paused edit is heard.
                        state_d = resume_q;
                        note_d  = (resume_q == S_PLAY) ? note_cur : 12'h000;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.high    = note_q[11:8];
    assign bus.med     = note_q[7:4];
    assign bus.low     = note_q[3:0];
    assign bus.cs      = cs_q;
    assign bus.playing = (state_q != S_IDLE);
    assign bus.done    = done_q;
endmodule

// File: doc/score_player.md
# score_player

Score sequencer feeding the buzzer tone stage. It holds a writable score memory of note entries and steps through them on a divided beat tick. It drives the `{high, med, low}` note-code nibbles and the `cs` display index that the tone generator and seven-segment logic consume. It supports start, pause and stop control, an optional loop mode, and a compile-time articulation gap between notes.

## Interface

Parameters:
- `TICK_DIV`, 12500000: `sys_clk` cycles per beat tick (4 Hz at 50 MHz); minimum 2.
- `ADDR_W`, 5: score memory address width; depth is 2^ADDR_W.
- `LOOP`, 0: 1 restarts at address 0 on end marker; 0 stops.

Ports:
- `sys_clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; begins playback at address 0 from IDLE.
- `pause` in 1: single-cycle pulse; toggles PLAY/GAP ↔ PAUSE.
- `stop` in 1: single-cycle pulse; aborts to IDLE.
- `wr_en` in 1: score write strobe.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in 16: entry `[15:12]` duration in ticks (0 = end marker), `[11:8]` high, `[7:4]` med, `[3:0]` low.
- `high`, `med`, `low` out 4 each: current note code; all zero = rest.
- `cs` out 3: `addr[2:0]` of the current entry.
- `playing` out 1: high in PLAY, GAP and PAUSE.
- `done` out 1: one-cycle pulse on natural end of score.

## Operation

- Memory:
  - Written synchronously when `wr_en`; read combinationally at `addr`.
  - Contents are not reset.
  - Writes are allowed during playback. A write to the entry about to be loaded is seen if it lands at least one cycle before the load.
- States: IDLE, PLAY, GAP, PAUSE. Reset enters IDLE.
- Reset values: `high`, `med`, `low`, `cs` = 0; `playing` = 0; `done` = 0; `addr` = 0; tick counter = 0; `remain` = 0.
- Load(a):
  - `addr` ← a.
  - Note outputs ← `mem[a][11:0]`.
  - `remain` ← `mem[a][15:12]`.
- IDLE:
  - On `start`: Load(0), go to PLAY, clear the tick counter.
  - If `mem[0]` duration is 0: stay in IDLE, outputs 0, pulse `done`.
- PLAY, on tick:
  - If `remain` > 1: decrement `remain`.
  - Otherwise the note ends and the next address is `addr+1`, wrapping from 2^ADDR_W−1 to 0.
  - If the next entry duration is ≠ 0: Load(next).
  - If the next entry duration is 0 and LOOP=1: Load(0). If `mem[0]` is also 0, go to IDLE with `done`.
  - If the next entry duration is 0 and LOOP=0: go to IDLE, outputs ← 0, `cs` ← 0, pulse `done`.
- PAUSE:
  - Outputs are forced to 0 (silence).
  - `addr`, `remain` and the tick counter are frozen.
  - On resume, the note is restored from `mem[addr]`, `remain` keeps its frozen value, and the previous state (PLAY or GAP) is re-entered.
- `stop` in any state: go to IDLE, outputs 0, `addr` 0, no `done`.
- Control priority in one cycle: `stop` > `start` > `pause`.
  - `start` outside IDLE is ignored.
  - `pause` in IDLE is ignored.
- Tick counter: counts 0..TICK_DIV−1 only in PLAY/GAP and emits the tick when it equals TICK_DIV−1.

## Timing

- Outputs are registered. Every output change appears the cycle after the causing event (control pulse or tick cycle).
- `start` at cycle N: entry 0 is on the outputs at N+1. The first tick is at N+TICK_DIV, so entry 0 lasts `dur`×TICK_DIV cycles.
- `done` is high for exactly the one cycle on which IDLE is entered naturally.
- `pause` and `stop` take effect at N+1. A tick coincident with `pause` is discarded.
- Asynchronous `rst` mid-note: outputs are 0 immediately, IDLE; the memory is preserved.

## Configuration

- `SCORE_GAP_EN` defined:
  - When a note with a nonzero successor ends, the block enters GAP for one tick with outputs 0. `cs` holds the old address.
  - Load(next) happens at the end of that tick. Each note therefore spans `dur`+1 ticks.
  - End-marker handling is unchanged; there is no gap before IDLE.
- `SCORE_GAP_EN` undefined: the GAP state is absent, and notes load back-to-back on the ending tick.

## Test plan

All scenarios use TICK_DIV=4, ADDR_W=3, gap off unless stated.

- Basic playback:
  - Stimulus: write [0]=0x2001, [1]=0x1010, [2]=0x0000, pulse `start`.
  - Required: {h,m,l}=0x001 for 8 cycles, then 0x010 for 4 cycles, then 0.
  - Required: `done` is a single pulse and `playing` drops with it.
- Loop:
  - Stimulus: LOOP=1 with the same score.
  - Required: the sequence 0x001 ×8 cycles, 0x010 ×4 cycles repeats; `done` never asserts; `cs` follows 0,1,0.
- Pause and resume:
  - Stimulus: pause 2 cycles into note 0, hold 10 cycles, pulse `pause` again.
  - Required: outputs 0 for the 10 cycles, then 0x001 for the remaining 6 cycles before 0x010.
- Stop priority:
  - Stimulus: `stop` and `pause` in the same cycle during PLAY.
  - Required: IDLE and outputs 0 on the next cycle; no `done`.
  - Stimulus: a later `start`.
  - Required: playback restarts at entry 0.
- Gap and wrap:
  - Stimulus: `SCORE_GAP_EN` on, all 8 entries 0x1100, LOOP=0.
  - Required: 0x100 for 4 cycles, then rest for 4 cycles, repeating; `cs` wraps 7→0 with no `done`.
- Edge cases:
  - Stimulus: empty score ([0]=0) then `start`.
  - Required: `done` at N+1, outputs stay 0.
  - Stimulus: `rst` mid-note.
  - Required: all outputs 0 asynchronously; the memory is retained, so `start` replays the score.
